switch_allocator: RTL and testbench

Separable input-first switch allocator with downstream credit tracking. It sits after the VC allocator in the router pipeline and chooses, every cycle, at most one input VC per input port and at most one input port per output port to traverse the crossbar. It issues only grants whose allocated downstream VC holds a free buffer slot. It keeps one credit counter per downstream VC and round-robin pointers for fairness at both arbitration stages.

---
 rtl/switch_allocator_pkg.sv | 26 ++
 rtl/switch_allocator_arbiter.sv | 27 ++
 rtl/switch_allocator.sv | 172 +++++++++++++++++
 tb/tb_switch_allocator.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/switch_allocator_pkg.sv
// Shared router parameters and port encoding for the switch allocator.
// The numeric value of port_t is the physical port index.
package switch_allocator_pkg;

    localparam int NOC_PORT_NUM    = 5;
    localparam int NOC_VC_NUM      = 2;
    localparam int NOC_VC_TOTAL    = NOC_PORT_NUM * NOC_VC_NUM;
    localparam int NOC_BUFFER_SIZE = 8;

    localparam int PORT_SIZE = $clog2(NOC_PORT_NUM);
    localparam int VC_SIZE   = (NOC_VC_NUM > 1) ? $clog2(NOC_VC_NUM) : 1;

    typedef enum logic [PORT_SIZE-1:0] {
        LOCAL = 3'd0,
        NORTH = 3'd1,
        SOUTH = 3'd2,
        EAST  = 3'd3,
        WEST  = 3'd4
    } port_t;

    // Flat index of downstream VC (port, vc).
    function automatic int flat_vc(input int port, input int vc, input int vc_num);
        return port * vc_num + vc;
    endfunction

endpackage

// File: rtl/switch_allocator_arbiter.sv
// Combinational round-robin arbiter: the first requester at or after the
// pointer (wrapping) wins; pointer storage lives in the caller.
module round_robin_arbiter #(
    parameter int N     = 2,
    parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic [N-1:0]     grant_o,
    output logic             valid_o
);

    always_comb begin
        int idx;
        grant_o = '0;
        valid_o = 1'b0;
        idx     = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr_i) + k) % N;
            if (!valid_o && req_i[idx]) begin
                grant_o[idx] = 1'b1;
                valid_o      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/switch_allocator.sv
// Separable input-first switch allocator: per-input-port VC arbitration, then
// per-output-port arbitration, gated by downstream credit counters.
module switch_allocator
    import switch_allocator_pkg::*;
#(
    parameter int VC_TOTAL    = NOC_VC_TOTAL,
    parameter int PORT_NUM    = NOC_PORT_NUM,
    parameter int VC_NUM      = NOC_VC_NUM,
    parameter int BUFFER_SIZE = NOC_BUFFER_SIZE
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [VC_TOTAL-1:0]                  request_i,
    input  logic [VC_TOTAL-1:0][PORT_SIZE-1:0]   out_port_i,
    input  logic [VC_TOTAL-1:0][VC_SIZE-1:0]     vc_sel_i,
    input  logic [VC_TOTAL-1:0]                  credit_i,
    output logic [VC_TOTAL-1:0]                  grant_o,
    output logic [PORT_NUM-1:0][PORT_SIZE-1:0]   xbar_sel_o,
    output logic [PORT_NUM-1:0]                  xbar_valid_o,
    output logic [VC_TOTAL-1:0]                  not_full_o
);

    localparam int CNT_W = $clog2(BUFFER_SIZE + 1);

    logic [VC_TOTAL-1:0][CNT_W-1:0]     cnt_q, cnt_d;
    logic [PORT_NUM-1:0][VC_SIZE-1:0]   in_ptr_q, in_ptr_d;
    logic [PORT_NUM-1:0][PORT_SIZE-1:0] out_ptr_q, out_ptr_d;

    logic [VC_TOTAL-1:0]                eligible;
    logic [PORT_NUM-1:0][VC_NUM-1:0]    s1_grant;
    logic [PORT_NUM-1:0]                s1_valid;
    logic [PORT_NUM-1:0][PORT_SIZE-1:0] cand_port;
    // s2_req/s2_grant are indexed [output port][input port]
    logic [PORT_NUM-1:0][PORT_NUM-1:0]  s2_req;
    logic [PORT_NUM-1:0][PORT_NUM-1:0]  s2_grant;
    logic [PORT_NUM-1:0]                s2_valid;
    logic [PORT_NUM-1:0]                port_won;
    logic [VC_TOTAL-1:0]                grant_raw;
    logic [VC_TOTAL-1:0]                consume;

    always_comb begin
        int j;
        eligible = '0;
        j        = 0;
        for (int i = 0; i < VC_TOTAL; i++) begin
            if (int'(out_port_i[i]) < PORT_NUM) begin
                j = flat_vc(int'(out_port_i[i]), int'(vc_sel_i[i]), VC_NUM);
                if (j < VC_TOTAL && cnt_q[j] != '0) begin
                    eligible[i] = request_i[i];
                end
            end
        end
    end

    for (genvar gi = 0; gi < PORT_NUM; gi++) begin : g_in_arb
        round_robin_arbiter #(
            .N     (VC_NUM),
            .PTR_W (VC_SIZE)
        ) u_in_arb (
            .req_i   (eligible[gi*VC_NUM +: VC_NUM]),
            .ptr_i   (in_ptr_q[gi]),
            .grant_o (s1_grant[gi]),
            .valid_o (s1_valid[gi])
        );
    end

    always_comb begin
        cand_port = '0;
        s2_req    = '0;
        for (int q = 0; q < PORT_NUM; q++) begin
            for (int k = 0; k < VC_NUM; k++) begin
                if (s1_grant[q][k]) begin
                    cand_port[q] = out_port_i[q*VC_NUM + k];
                end
            end
            for (int p = 0; p < PORT_NUM; p++) begin
                if (s1_valid[q] && int'(cand_port[q]) == p) begin
                    s2_req[p][q] = 1'b1;
                end
            end
        end
    end

    for (genvar gi = 0; gi < PORT_NUM; gi++) begin : g_out_arb
        round_robin_arbiter #(
            .N     (PORT_NUM),
            .PTR_W (PORT_SIZE)
        ) u_out_arb (
            .req_i   (s2_req[gi]),
            .ptr_i   (out_ptr_q[gi]),
            .grant_o (s2_grant[gi]),
            .valid_o (s2_valid[gi])
        );
    end

    // Final grants, crossbar select, pointer and credit next-state.
    always_comb begin
        port_won     = '0;
        grant_raw    = '0;
        consume      = '0;
        xbar_sel_o   = '0;
        xbar_valid_o = '0;
        grant_o      = '0;
        in_ptr_d     = in_ptr_q;
        out_ptr_d    = out_ptr_q;
        cnt_d        = cnt_q;

        for (int p = 0; p < PORT_NUM; p++) begin
            for (int q = 0; q < PORT_NUM; q++) begin
                if (s2_grant[p][q]) begin
                    port_won[q]   = 1'b1;
                    xbar_sel_o[p] = PORT_SIZE'(q);
                    out_ptr_d[p]  = PORT_SIZE'((q + 1) % PORT_NUM);
                end
            end
        end
        xbar_valid_o = s2_valid;

        // A stage-1 loser keeps its pointer so it retries first next time.
        for (int q = 0; q < PORT_NUM; q++) begin
            for (int k = 0; k < VC_NUM; k++) begin
                if (port_won[q] && s1_grant[q][k]) begin
                    grant_raw[q*VC_NUM + k] = 1'b1;
                    in_ptr_d[q]             = VC_SIZE'((k + 1) % VC_NUM);
                end
            end
        end

        for (int i = 0; i < VC_TOTAL; i++) begin
            if (grant_raw[i]) begin
                consume[flat_vc(int'(out_port_i[i]), int'(vc_sel_i[i]), VC_NUM)] = 1'b1;
            end
        end

        for (int j = 0; j < VC_TOTAL; j++) begin
            if (consume[j] && !credit_i[j]) begin
                cnt_d[j] = cnt_q[j] - CNT_W'(1);
            end else if (credit_i[j] && !consume[j] && cnt_q[j] != CNT_W'(BUFFER_SIZE)) begin
                cnt_d[j] = cnt_q[j] + CNT_W'(1);
            end
        end

        if (!rst) begin
            xbar_sel_o   = '0;
            xbar_valid_o = '0;
        end else begin
            grant_o = grant_raw;
        end
    end

    always_comb begin
        not_full_o = '0;
        for (int j = 0; j < VC_TOTAL; j++) begin
            not_full_o[j] = (cnt_q[j] != '0);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int j = 0; j < VC_TOTAL; j++) begin
                cnt_q[j] <= CNT_W'(BUFFER_SIZE);
            end
            in_ptr_q  <= '0;
            out_ptr_q <= '0;
        end else begin
            cnt_q     <= cnt_d;
            in_ptr_q  <= in_ptr_d;
            out_ptr_q <= out_ptr_d;
        end
    end

endmodule

// File: tb/tb_switch_allocator.sv
// Directed and randomized checks of switch_allocator against hand-derived
// grant sequences and a credit-counter reference model.
module tb_switch_allocator;
    import switch_allocator_pkg::*;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [9:0]            request;
    logic [9:0][2:0]       out_port;
    logic [9:0][0:0]       vc_sel;
    logic [9:0]            credit;
    logic [9:0]            grant_o;
    logic [4:0][2:0]       xbar_sel_o;
    logic [4:0]            xbar_valid_o;
    logic [9:0]            not_full_o;

    int n_checks = 0;
    int n_fail   = 0;
    int cnt_m[10];

    switch_allocator dut (
        .clk          (clk),
        .rst          (rst),
        .request_i    (request),
        .out_port_i   (out_port),
        .vc_sel_i     (vc_sel),
        .credit_i     (credit),
        .grant_o      (grant_o),
        .xbar_sel_o   (xbar_sel_o),
        .xbar_valid_o (xbar_valid_o),
        .not_full_o   (not_full_o)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic clear_inputs();
        request  = '0;
        out_port = '0;
        vc_sel   = '0;
        credit   = '0;
    endtask

    task automatic set_req(input int vc, input port_t port, input int sel);
        request[vc]  = 1'b1;
        out_port[vc] = port;
        vc_sel[vc]   = 1'(sel);
    endtask

    // Advance the reference credit counters by what this cycle commits.
    task automatic model_edge();
        logic [9:0] cons;
        cons = '0;
        for (int i = 0; i < 10; i++) begin
            if (grant_o[i] && int'(out_port[i]) < 5) cons[int'(out_port[i]) * 2 + int'(vc_sel[i])] = 1'b1;
        end
        for (int j = 0; j < 10; j++) begin
            if (cons[j] && !credit[j]) begin
                if (cnt_m[j] > 0) cnt_m[j]--;
            end else if (credit[j] && !cons[j] && cnt_m[j] < 8) begin
                cnt_m[j]++;
            end
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst     = 1'b0;
        request = 10'($urandom);
        for (int i = 0; i < 10; i++) begin
            out_port[i] = 3'($urandom_range(0, 4));
            vc_sel[i]   = 1'($urandom);
        end
        credit = 10'($urandom);
        #1;
        check_eq("rst_grant", 32'(grant_o), 0);
        check_eq("rst_xvalid", 32'(xbar_valid_o), 0);
        check_eq("rst_xsel", 32'(xbar_sel_o), 0);
        check_eq("rst_not_full", 32'(not_full_o), 32'h3FF);
        @(posedge clk);
        #1;
        check_eq("rst_hold_grant", 32'(grant_o), 0);
        for (int j = 0; j < 10; j++) cnt_m[j] = 8;
        clear_inputs();
        rst = 1'b1;
    endtask

    // Hold the current request pattern for n cycles; return the number of grants seen.
    task automatic count_grants(input int n, output int total);
        total = 0;
        for (int c = 0; c < n; c++) begin
            #1;
            if (grant_o != '0) total++;
            step();
        end
    endtask

    initial begin
        logic [9:0] exp_g2 [4];
        logic [2:0] exp_s2 [4];
        logic [9:0] exp_g3 [4];
        int         total;
        exp_g2 = '{10'b0000000001, 10'b0000000100, 10'b0000000001, 10'b0000000100};
        exp_s2 = '{3'd0, 3'd1, 3'd0, 3'd1};
        exp_g3 = '{10'b0000000001, 10'b0000000010, 10'b0000000001, 10'b0000000010};
        clear_inputs();
        for (int j = 0; j < 10; j++) cnt_m[j] = 8;
        #2;

        // Reset, then a lone request is granted in the first cycle.
        do_reset();
        set_req(0, EAST, 1);
        #1;
        check_eq("first_grant", 32'(grant_o), 32'h001);
        check_eq("first_xvalid", 32'(xbar_valid_o), 32'b01000);
        check_eq("first_xsel_east", 32'(xbar_sel_o[EAST]), 0);
        step();

        // Output contention: VC0 and VC2 both to NORTH vc0.
        do_reset();
        set_req(0, NORTH, 0);
        set_req(2, NORTH, 0);
        for (int c = 0; c < 4; c++) begin
            #1;
            check_eq($sformatf("outcont_grant%0d", c), 32'(grant_o), 32'(exp_g2[c]));
            check_eq($sformatf("outcont_xsel%0d", c), 32'(xbar_sel_o[NORTH]), 32'(exp_s2[c]));
            check_eq($sformatf("outcont_xvalid%0d", c), 32'(xbar_valid_o), 32'b00010);
            step();
        end

        // Input contention: VC0 and VC1 share port 0, distinct outputs.
        do_reset();
        set_req(0, SOUTH, 0);
        set_req(1, WEST, 0);
        for (int c = 0; c < 4; c++) begin
            #1;
            check_eq($sformatf("incont_grant%0d", c), 32'(grant_o), 32'(exp_g3[c]));
            step();
        end

        // Credit exhaustion on downstream VC 1 (LOCAL vc1).
        do_reset();
        set_req(4, LOCAL, 1);
        for (int c = 0; c < 12; c++) begin
            #1;
            check_eq($sformatf("exhaust_grant%0d", c), 32'(grant_o), (c < 8) ? 32'h010 : 32'h000);
            step();
        end
        check_eq("exhaust_not_full", 32'(not_full_o), 32'h3FD);
        credit[1] = 1'b1;
        #1;
        check_eq("exhaust_credit_cycle", 32'(grant_o), 0);
        step();
        credit[1] = 1'b0;
        count_grants(4, total);
        check_eq("exhaust_one_more", 32'(total), 1);
        check_eq("exhaust_not_full_again", 32'(not_full_o), 32'h3FD);

        // Grant and credit together at cnt=3 leaves cnt at 3.
        do_reset();
        set_req(4, LOCAL, 1);
        count_grants(5, total);
        check_eq("simul_pre_grants", 32'(total), 5);
        credit[1] = 1'b1;
        #1;
        check_eq("simul_grant", 32'(grant_o), 32'h010);
        step();
        credit[1] = 1'b0;
        count_grants(6, total);
        check_eq("simul_remaining", 32'(total), 3);

        // Credit at full is dropped.
        do_reset();
        credit[1] = 1'b1;
        step();
        credit[1] = 1'b0;
        set_req(4, LOCAL, 1);
        count_grants(10, total);
        check_eq("sat_total", 32'(total), 8);

        // Randomized traffic against the reference credit model.
        do_reset();
        for (int c = 0; c < 1000; c++) begin
            logic [9:0] elig;
            int         viol;
            int         in_cnt[5];
            int         out_cnt[5];
            int         out_src[5];
            logic [9:0] nf_m;
            if (c == 600) do_reset();
            request = 10'($urandom);
            for (int i = 0; i < 10; i++) begin
                out_port[i] = 3'($urandom_range(0, 4));
                vc_sel[i]   = 1'($urandom);
                credit[i]   = ($urandom_range(0, 3) == 0);
            end
            #1;
            viol = 0;
            elig = '0;
            nf_m = '0;
            for (int p = 0; p < 5; p++) begin
                in_cnt[p]  = 0;
                out_cnt[p] = 0;
                out_src[p] = 0;
            end
            for (int j = 0; j < 10; j++) nf_m[j] = (cnt_m[j] != 0);
            for (int i = 0; i < 10; i++) begin
                int d;
                d       = int'(out_port[i]) * 2 + int'(vc_sel[i]);
                elig[i] = request[i] && cnt_m[d] != 0;
                if (grant_o[i]) begin
                    if (!elig[i]) viol++;
                    in_cnt[i / 2]++;
                    out_cnt[int'(out_port[i])]++;
                    out_src[int'(out_port[i])] = i / 2;
                end
            end
            for (int p = 0; p < 5; p++) begin
                if (in_cnt[p] > 1 || out_cnt[p] > 1) viol++;
                if (xbar_valid_o[p] != (out_cnt[p] != 0)) viol++;
                if (int'(xbar_sel_o[p]) != out_src[p]) viol++;
            end
            if (elig != '0 && grant_o == '0) viol++;
            check_eq($sformatf("rand_legal%0d", c), 32'(viol), 0);
            check_eq($sformatf("rand_not_full%0d", c), 32'(not_full_o), 32'(nf_m));
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
